// File: rtl/msg_pkg.sv
// Shared definitions for the message router: serial receiver state encodings,
// default bit timing, and the header framing constants used by the demux.
package msg_pkg;

    localparam int DEFAULT_CLOCKS_PER_BIT = 868;  // 100 MHz / 115200 baud

    localparam logic [7:0] SYNC_BYTE_0   = 8'h34;
    localparam logic [7:0] SYNC_BYTE_1   = 8'h12;
    localparam int         HEADER_LENGTH = 8;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START_BIT = 3'd1,
        RX_DATA_BITS = 3'd2,
        RX_STOP_BIT  = 3'd3,
        RX_DELIVER   = 3'd4,
        RX_WAIT_IDLE = 3'd5
    } rx_state_t;

endpackage

// File: rtl/serial_byte_receiver_if.sv
// Serial line in, byte stream out, between the UART pin and the header demux.
// Handshake: MessageByteReady is a one-cycle valid strobe with no ready/backpressure;
// MessageByte is valid in that cycle and held until the next good byte.
interface serial_byte_receiver_if;
    import msg_pkg::*;

    logic       SerialIn;
    logic [7:0] MessageByte;
    logic       MessageByteReady;
    logic       FramingError;
    logic       Busy;
    rx_state_t  State;

    modport master (
        input  SerialIn,
        output MessageByte, MessageByteReady, FramingError, Busy, State
    );

    modport slave (
        output SerialIn,
        input  MessageByte, MessageByteReady, FramingError, Busy, State
    );
endinterface

// File: rtl/bit_synchronizer.sv
// Two-flop synchronizer for a single asynchronous input; reset value selectable
// so idle-high lines do not glitch low out of reset.
module bit_synchronizer #(
    parameter logic ResetValue = 1'b1
) (
    input  logic Clock,
    input  logic Clear,
    input  logic AsyncIn,
    output logic SyncOut
);
    logic meta;

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            meta    <= ResetValue;
            SyncOut <= ResetValue;
        end else begin
            meta    <= AsyncIn;
            SyncOut <= meta;
        end
    end
endmodule

// File: rtl/serial_byte_receiver.sv
// 8N1 UART receiver: finds the start bit, samples eight data bits LSB first at
// mid-bit, checks the stop bit and strobes each good byte for one cycle.
module serial_byte_receiver
    import msg_pkg::*;
#(
    parameter int ClocksPerBit = DEFAULT_CLOCKS_PER_BIT
) (
    input  logic Clock,
    input  logic Clear,
    serial_byte_receiver_if.master bus
);
    localparam int CntW = $clog2(ClocksPerBit);
    localparam logic [CntW-1:0] HalfLast = CntW'(ClocksPerBit / 2 - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(ClocksPerBit - 1);

    logic            rx;
    rx_state_t       state, state_next;
    logic [CntW-1:0] cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic            deliver_d, ferr_d, busy;
    logic [7:0]      byte_q;
    logic            ready_q, ferr_q;

    bit_synchronizer #(.ResetValue(1'b1)) u_sync (
        .Clock  (Clock),
        .Clear  (Clear),
        .AsyncIn(bus.SerialIn),
        .SyncOut(rx)
    );

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) state <= RX_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RX_IDLE:      if (!rx) state_next = RX_START_BIT;
            RX_START_BIT: if (cnt == HalfLast) state_next = rx ? RX_IDLE : RX_DATA_BITS;
            RX_DATA_BITS: if (cnt == BitLast && bit_idx == 3'd7) state_next = RX_STOP_BIT;
            RX_STOP_BIT:  if (cnt == BitLast) state_next = rx ? RX_DELIVER : RX_WAIT_IDLE;
            RX_DELIVER:   state_next = RX_IDLE;
            RX_WAIT_IDLE: if (rx) state_next = RX_IDLE;
            default:      state_next = RX_IDLE;
        endcase
    end

    // The outputs are registered on the stop-sample edge so the strobe lands in the Deliver cycle.
    always_comb begin
        busy      = (state != RX_IDLE);
        deliver_d = (state == RX_STOP_BIT) && (cnt == BitLast) && rx;
        ferr_d    = (state == RX_STOP_BIT) && (cnt == BitLast) && !rx;
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                RX_START_BIT: cnt <= (cnt == HalfLast) ? '0 : cnt + CntW'(1);
                RX_DATA_BITS: begin
                    if (cnt == BitLast) begin
                        cnt     <= '0;
                        shift   <= {rx, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                RX_STOP_BIT:  cnt <= cnt + CntW'(1);
                default: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            byte_q  <= 8'h00;
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            ready_q <= deliver_d;
            ferr_q  <= ferr_d;
            if (deliver_d) byte_q <= shift;
        end
    end

    assign bus.MessageByte      = byte_q;
    assign bus.MessageByteReady = ready_q;
    assign bus.FramingError     = ferr_q;
    assign bus.Busy             = busy;
    assign bus.State            = state;
endmodule

// File: tb/tb_serial_byte_receiver.sv
// Directed bench for serial_byte_receiver at 16 clocks per bit.
module tb_serial_byte_receiver;
    import msg_pkg::*;

    localparam int Cpb = 16;
    // Pin driven just after edge c: receiver sees it at c+3 (t0), stop sample at t0+8+144.
    localparam int PulseDelay = 3 + Cpb / 2 + 9 * Cpb;

    logic Clock = 1'b0;
    logic Clear = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   ferr_cnt = 0;
    int   last_ferr_cyc = -1;
    logic monitor_on = 1'b0;
    logic [7:0] exp_q[$];
    int         exp_cyc_q[$];

    serial_byte_receiver_if bus();

    serial_byte_receiver #(.ClocksPerBit(Cpb)) dut (
        .Clock(Clock),
        .Clear(Clear),
        .bus  (bus)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Scoreboard: every strobe must match the next expected byte and its cycle.
    always @(negedge Clock) begin
        if (monitor_on) begin
            if (bus.MessageByteReady) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    check_eq("byte", {24'd0, bus.MessageByte}, {24'd0, exp_q.pop_front()});
                    check_eq("ready_cycle", cyc, exp_cyc_q.pop_front());
                end
            end
            if (bus.FramingError) begin
                ferr_cnt++;
                last_ferr_cyc = cyc;
            end
        end
    end

    task automatic idle(input int n);
        bus.SerialIn = 1'b1;
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        bus.SerialIn = b;
        repeat (Cpb) @(posedge Clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop, output int start_cyc);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
        drive_bit(stop);
    endtask

    task automatic expect_byte(input logic [7:0] data, input int start_cyc);
        exp_q.push_back(data);
        exp_cyc_q.push_back(start_cyc + PulseDelay);
    endtask

    task automatic check_at_negedge(input string tag, input logic [31:0] obs_sel, input logic [31:0] exp);
        check_eq(tag, obs_sel, exp);
    endtask

    initial begin
        int c0, c1;
        bus.SerialIn = 1'b1;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check_eq("rst_byte",  {24'd0, bus.MessageByte}, 32'h00);
        check_eq("rst_ready", {31'd0, bus.MessageByteReady}, 32'd0);
        check_eq("rst_ferr",  {31'd0, bus.FramingError}, 32'd0);
        check_eq("rst_busy",  {31'd0, bus.Busy}, 32'd0);
        check_eq("rst_state", {29'd0, bus.State}, {29'd0, RX_IDLE});
        @(posedge Clock); #1;
        Clear = 1'b1;
        monitor_on = 1'b1;
        idle(10);

        // Single frame
        expect_byte(8'h34, cyc);
        send_frame(8'h34, 1'b1, c0);
        idle(20);
        check_eq("single_ferr_cnt", ferr_cnt, 0);
        check_eq("single_hold", {24'd0, bus.MessageByte}, 32'h34);

        // Back-to-back, second start 160 cycles after the first
        expect_byte(8'h34, cyc);
        send_frame(8'h34, 1'b1, c0);
        expect_byte(8'h12, cyc);
        send_frame(8'h12, 1'b1, c1);
        check_eq("b2b_spacing", c1 - c0, 160);
        idle(20);
        check_eq("b2b_pending", exp_q.size(), 0);

        // Start-bit glitch: low for 5 cycles
        bus.SerialIn = 1'b0;
        repeat (5) @(posedge Clock);
        #1 bus.SerialIn = 1'b1;
        @(negedge Clock);
        check_eq("glitch_busy", {31'd0, bus.Busy}, 32'd1);
        idle(20);
        @(negedge Clock);
        check_eq("glitch_idle", {29'd0, bus.State}, {29'd0, RX_IDLE});
        check_eq("glitch_hold", {24'd0, bus.MessageByte}, 32'h12);
        @(posedge Clock); #1;

        // Bad stop bit
        send_frame(8'h55, 1'b0, c0);
        idle(20);
        check_eq("stop_ferr_cnt", ferr_cnt, 1);
        check_eq("stop_ferr_cycle", last_ferr_cyc, c0 + PulseDelay);
        check_eq("stop_hold", {24'd0, bus.MessageByte}, 32'h12);

        // Break, then a good frame
        c0 = cyc;
        bus.SerialIn = 1'b0;
        repeat (400) @(posedge Clock);
        #1;
        idle(30);
        check_eq("break_ferr_cnt", ferr_cnt, 2);
        check_eq("break_ferr_cycle", last_ferr_cyc, c0 + PulseDelay);
        expect_byte(8'hA5, cyc);
        send_frame(8'hA5, 1'b1, c0);
        idle(20);
        check_eq("break_pending", exp_q.size(), 0);

        // Clear mid-byte (bit 3 of 0xFF)
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        bus.SerialIn = 1'b1;
        repeat (8) @(posedge Clock);
        #1 Clear = 1'b0;
        @(negedge Clock);
        check_eq("clr_byte",  {24'd0, bus.MessageByte}, 32'h00);
        check_eq("clr_ready", {31'd0, bus.MessageByteReady}, 32'd0);
        check_eq("clr_ferr",  {31'd0, bus.FramingError}, 32'd0);
        check_eq("clr_busy",  {31'd0, bus.Busy}, 32'd0);
        check_eq("clr_state", {29'd0, bus.State}, {29'd0, RX_IDLE});
        @(posedge Clock); #1;
        Clear = 1'b1;
        idle(30);
        expect_byte(8'h0F, cyc);
        send_frame(8'h0F, 1'b1, c0);
        idle(20);
        check_eq("final_byte", {24'd0, bus.MessageByte}, 32'h0F);
        check_eq("final_pending", exp_q.size(), 0);
        check_eq("final_ferr_cnt", ferr_cnt, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
